// File: rtl/popcount_pattern_gen.sv
// Pattern generator emitting WIDTH-bit vectors of a known Hamming weight, rotated beat to beat.
// Optional macro POPGEN_LFSR_EN replaces the unit rotation step with an LFSR-derived step.
module popcount_pattern_gen #(
    parameter int WIDTH = 23,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CW-1:0]    req_weight,
    input  logic [7:0]       req_beats,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_vec,
    output logic [CW-1:0]    out_weight,
    output logic             out_last
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready high
    // EMIT  | presenting beats until the last one is accepted
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [CW-1:0] W_CNT = CW'(WIDTH);
    localparam logic [CW:0]   W_EXT = (CW+1)'(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [CW-1:0]    rot_q, rot_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             out_valid_d, out_last_d;
    logic [WIDTH-1:0] out_vec_d;
    logic [CW-1:0]    out_weight_d;
    logic [CW-1:0]    k_req;
    logic [CW-1:0]    step;
    logic [CW:0]      rot_sum;
    logic [CW-1:0]    rot_inc;

    function automatic logic [WIDTH-1:0] gen_vec(input logic [CW-1:0] k, input logic [CW-1:0] r);
        logic [WIDTH-1:0]   therm;
        logic [2*WIDTH-1:0] dbl;
        for (int i = 0; i < WIDTH; i++) therm[i] = (i < int'(k));
        // Upper half of the shifted doubled word is the rotate-left result.
        dbl = {therm, therm} << r;
        return dbl[2*WIDTH-1:WIDTH];
    endfunction

`ifdef POPGEN_LFSR_EN
    logic [7:0] lfsr_q;
    logic [CW:0] l_ext;
    logic [CW:0] step_ext;

    assign l_ext    = (CW+1)'(lfsr_q[4:0]);
    assign step_ext = (l_ext >= W_EXT) ? l_ext - W_EXT : l_ext;
    assign step     = CW'(step_ext);

    // Fibonacci taps for x^8+x^6+x^5+x^4+1; advances once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'h01;
        end else if (out_valid && out_ready) begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end
`else
    assign step = CW'(1);
`endif

    assign k_req     = (req_weight > W_CNT) ? W_CNT : req_weight;
    assign rot_sum   = {1'b0, rot_q} + {1'b0, step};
    assign rot_inc   = CW'((rot_sum >= W_EXT) ? rot_sum - W_EXT : rot_sum);
    assign req_ready = (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            rot_q      <= '0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_weight <= '0;
            out_last   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            rot_q      <= rot_d;
            cnt_q      <= cnt_d;
            out_valid  <= out_valid_d;
            out_vec    <= out_vec_d;
            out_weight <= out_weight_d;
            out_last   <= out_last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        rot_d        = rot_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid;
        out_vec_d    = out_vec;
        out_weight_d = out_weight;
        out_last_d   = out_last;
        case (state_q)
            IDLE: begin
                // A zero-beat request is consumed here without leaving IDLE.
                if (req_valid && (req_beats != 8'd0)) begin
                    state_d      = EMIT;
                    k_d          = k_req;
                    rot_d        = '0;
                    cnt_d        = req_beats;
                    out_valid_d  = 1'b1;
                    out_vec_d    = gen_vec(k_req, '0);
                    out_weight_d = k_req;
                    out_last_d   = (req_beats == 8'd1);
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (cnt_q == 8'd1) begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        rot_d        = '0;
                        out_valid_d  = 1'b0;
                        out_vec_d    = '0;
                        out_weight_d = '0;
                        out_last_d   = 1'b0;
                    end else begin
                        cnt_d      = cnt_q - 8'd1;
                        rot_d      = rot_inc;
                        out_vec_d  = gen_vec(k_q, rot_inc);
                        out_last_d = (cnt_q == 8'd2);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_popcount_pattern_gen.sv
// Directed bench for popcount_pattern_gen; LFSR-step checks build when POPGEN_LFSR_EN is defined.
module tb_popcount_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_weight;
    logic [7:0]  req_beats;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] out_vec;
    logic [4:0]  out_weight;
    logic        out_last;

    int checks   = 0;
    int failures = 0;

    popcount_pattern_gen #(.WIDTH(23), .CW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_weight (req_weight),
        .req_beats  (req_beats),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec),
        .out_weight (out_weight),
        .out_last   (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one request for a single cycle; returns on the negedge after acceptance.
    task automatic send_req(input logic [4:0] w, input logic [7:0] b);
        @(negedge clk);
        req_valid  = 1'b1;
        req_weight = w;
        req_beats  = b;
        @(negedge clk);
        req_valid  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_vec !== 23'h0 || out_weight !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b vec=%h w=%0d last=%b required all zero",
                     out_valid, out_vec, out_weight, out_last);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b valid=%b required ready=1 valid=0", req_ready, out_valid);
        end
    endtask

    task automatic test_extremes;
        send_req(5'd0, 8'd3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_vec !== 23'h0 || out_weight !== 5'd0 || out_last !== (i == 2)) begin
                failures++;
                $display("FAIL weight0 beat%0d: valid=%b vec=%h w=%0d last=%b required valid=1 vec=0 w=0 last=%b",
                         i, out_valid, out_vec, out_weight, out_last, (i == 2));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL weight0_end: valid=%b ready=%b required valid=0 ready=1", out_valid, req_ready);
        end
        send_req(5'd30, 8'd2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_vec !== 23'h7FFFFF || out_weight !== 5'd23 || out_last !== (i == 1)) begin
                failures++;
                $display("FAIL weight30 beat%0d: valid=%b vec=%h w=%0d last=%b required valid=1 vec=7fffff w=23 last=%b",
                         i, out_valid, out_vec, out_weight, out_last, (i == 1));
            end
            @(negedge clk);
        end
        send_req(5'd5, 8'd0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL beats0 cyc%0d: valid=%b ready=%b required valid=0 ready=1", i, out_valid, req_ready);
            end
            @(negedge clk);
        end
    endtask

`ifndef POPGEN_LFSR_EN
    task automatic test_basic;
        logic [22:0] ev [2];
        ev[0] = 23'h000007;
        ev[1] = 23'h00000E;
        send_req(5'd3, 8'd2);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_vec !== ev[i] || out_weight !== 5'd3 || out_last !== (i == 1)) begin
                failures++;
                $display("FAIL basic beat%0d: valid=%b vec=%h w=%0d last=%b required valid=1 vec=%h w=3 last=%b",
                         i, out_valid, out_vec, out_weight, out_last, ev[i], (i == 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_end: valid=%b ready=%b required valid=0 ready=1", out_valid, req_ready);
        end
    endtask

    task automatic test_wrap;
        logic [22:0] ev;
        send_req(5'd1, 8'd24);
        for (int i = 0; i < 24; i++) begin
            ev = (i == 23) ? 23'h000001 : (23'h000001 << i);
            checks++;
            if (out_valid !== 1'b1 || out_vec !== ev || out_weight !== 5'd1 || out_last !== (i == 23)) begin
                failures++;
                $display("FAIL wrap beat%0d: valid=%b vec=%h last=%b required vec=%h last=%b",
                         i + 1, out_valid, out_vec, out_last, ev, (i == 23));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [22:0] ev [4];
        ev[0] = 23'h000003;
        ev[1] = 23'h000006;
        ev[2] = 23'h00000C;
        ev[3] = 23'h000018;
        send_req(5'd2, 8'd4);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_vec !== ev[1] || out_last !== 1'b0) begin
                        failures++;
                        $display("FAIL stall cyc%0d: valid=%b vec=%h last=%b required valid=1 vec=%h last=0",
                                 s, out_valid, out_vec, out_last, ev[1]);
                    end
                end
                out_ready = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || out_vec !== ev[i] || out_weight !== 5'd2 || out_last !== (i == 3)) begin
                failures++;
                $display("FAIL bp beat%0d: valid=%b vec=%h w=%0d last=%b required vec=%h w=2 last=%b",
                         i, out_valid, out_vec, out_weight, out_last, ev[i], (i == 3));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_end: valid=%b required 0", out_valid);
        end
    endtask
`endif

    task automatic test_reset_mid;
        send_req(5'd1, 8'd4);
        checks++;
        if (out_valid !== 1'b1 || out_vec !== 23'h000001) begin
            failures++;
            $display("FAIL rmid beat1: valid=%b vec=%h required valid=1 vec=000001", out_valid, out_vec);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rmid beat2: valid=%b last=%b required valid=1 last=0", out_valid, out_last);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_vec !== 23'h0 || out_weight !== 5'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL rmid_async: valid=%b vec=%h w=%0d last=%b required all zero",
                     out_valid, out_vec, out_weight, out_last);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL rmid_after cyc%0d: valid=%b ready=%b required valid=0 ready=1",
                         i, out_valid, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        req_valid  = 1'b1;
        req_weight = 5'd23;
        req_beats  = 8'd2;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || req_ready !== 1'b0 || out_vec !== 23'h7FFFFF || out_last !== (i == 1)) begin
                failures++;
                $display("FAIL b2b first beat%0d: valid=%b ready=%b vec=%h last=%b required valid=1 ready=0 vec=7fffff last=%b",
                         i, out_valid, req_ready, out_vec, out_last, (i == 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b gap: valid=%b ready=%b required valid=0 ready=1", out_valid, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_vec !== 23'h7FFFFF || out_weight !== 5'd23 || out_last !== (i == 1)) begin
                failures++;
                $display("FAIL b2b second beat%0d: valid=%b vec=%h w=%0d last=%b required valid=1 vec=7fffff w=23 last=%b",
                         i, out_valid, out_vec, out_weight, out_last, (i == 1));
            end
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: valid=%b required 0", out_valid);
        end
    endtask

`ifdef POPGEN_LFSR_EN
    task automatic test_lfsr;
        logic [7:0]  lfsr_m;
        int          rot_m;
        logic [22:0] therm;
        logic [22:0] ev;
        logic [4:0]  w;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        lfsr_m = 8'h01;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            w = (r < 2) ? 5'd1 : 5'd7;
            therm = (23'h000001 << w) - 23'h000001;
            send_req(w, 8'd250);
            rot_m = 0;
            for (int b = 0; b < 250; b++) begin
                ev = (therm << rot_m) | (therm >> (23 - rot_m));
                checks++;
                if (out_valid !== 1'b1 || out_vec !== ev || out_last !== (b == 249)) begin
                    failures++;
                    $display("FAIL lfsr req%0d beat%0d: valid=%b vec=%h last=%b required vec=%h last=%b",
                             r, b, out_valid, out_vec, out_last, ev, (b == 249));
                end
                checks++;
                if ($countones(out_vec) != int'(out_weight) || out_weight !== w) begin
                    failures++;
                    $display("FAIL lfsr_pop req%0d beat%0d: popcount=%0d w=%0d required %0d",
                             r, b, $countones(out_vec), out_weight, w);
                end
                rot_m  = (rot_m + (int'(lfsr_m[4:0]) % 23)) % 23;
                lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
                @(negedge clk);
            end
        end
    endtask
`endif

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_weight = '0;
        req_beats  = '0;
        out_ready  = 1'b1;
        test_reset();
`ifndef POPGEN_LFSR_EN
        test_basic();
        test_wrap();
`endif
        test_extremes();
`ifndef POPGEN_LFSR_EN
        test_backpressure();
`endif
        test_reset_mid();
        test_back_to_back();
`ifdef POPGEN_LFSR_EN
        test_lfsr();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/popcount_pattern_gen.md
POPCOUNT_PATTERN_GEN -- requirements
Module: popcount_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 23: width of generated vector, equal to the popcount23 input width.
REQ-002 Parameter CW, default 5: count width, equal to the popcount23 output width.
REQ-003 Port clk  input  1: single clock, rising-edge active.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port req_valid  input  1: request present.
REQ-006 Port req_ready  output  1: request accepted when req_valid && req_ready.
REQ-007 Port req_weight  input  CW: requested Hamming weight.
REQ-008 Port req_beats  input  8: number of vectors to emit.
REQ-009 Port out_valid  output  1: out_vec valid.
REQ-010 Port out_ready  input  1: consumer accepts when out_valid && out_ready.
REQ-011 Port out_vec  output  WIDTH: generated vector with exactly the effective weight.
REQ-012 Port out_weight  output  CW: effective weight of out_vec, the exact reference count for the approximate popcount under test.
REQ-013 Port out_last  output  1: high on the final beat of a request.

Function
REQ-014 FSM states: IDLE and EMIT; req_ready = 1 only in IDLE.
- IDLE -> EMIT on request handshake with req_beats != 0.
- Request with req_beats == 0 is accepted; FSM stays IDLE; no output beat.
REQ-015 Effective weight k_eff = min(req_weight, WIDTH), latched on acceptance.
- Beat counter latched from req_beats.
- Rotation register rot cleared to 0 on acceptance.
REQ-016 Beat vector = thermometer code of k_eff ones (bits [k_eff-1:0]), rotated left by rot modulo WIDTH.
REQ-017 Latency: request handshake in cycle T -> out_valid = 1 in cycle T+1.
- All outputs are driven from registers.
REQ-018 While out_valid && !out_ready, out_vec, out_weight and out_last hold stable.
REQ-019 On output handshake:
- Beat counter decrements.
- rot <= (rot + step) mod WIDTH; rot never reaches WIDTH.
- Next vector is presented in the following cycle, so a full-throughput stream has no bubbles.
REQ-020 out_last = 1 when the beat counter equals 1.
- Handshake of the last beat -> IDLE; out_valid = 0 and req_ready = 1 in the next cycle.
REQ-021 A new request is never accepted in the same cycle as the last-beat handshake.
REQ-022 Step = 1 unless REQ-027 applies.
REQ-023 Weight boundaries: k_eff = 0 -> all-zero vector; k_eff = WIDTH -> all-ones vector, independent of rot.

Reset
REQ-024 rst_n low asynchronously forces the following, and may occur in any state including mid-EMIT or stalled:
- State = IDLE.
- out_valid = 0, out_last = 0.
- out_vec = 0, out_weight = 0.
- rot = 0, beat counter = 0.
- LFSR = 8'h01.
REQ-025 req_ready = 1 in the first cycle after rst_n deasserts.
REQ-026 Any request in flight at reset is discarded, with no partial beats after release.

Configuration
REQ-027 Macro POPGEN_LFSR_EN.
- Defined: step = L mod WIDTH, where L = bits [4:0] of an 8-bit Fibonacci LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'h01).
- The LFSR advances once per output handshake; the modulo is one conditional subtract.
- Undefined: step fixed at 1 and no LFSR logic is present.

Verification
REQ-028 Basic beats (macro off): weight=3, beats=2, out_ready=1 -> out_vec 0x000007 (last=0), then 0x00000E (last=1); out_weight=3 on both beats.
REQ-029 Rotation wrap (macro off): weight=1, beats=24 -> beat 23 = 0x400000, beat 24 = 0x000001 with last=1; no 23-bit overflow.
REQ-030 Weight extremes:
- weight=0, beats=3 -> three 0x000000 beats.
- weight=30, beats=2 -> out_vec 0x7FFFFF and out_weight=23 on both beats.
- beats=0 -> no out_valid, req_ready stays high.
REQ-031 Backpressure: out_ready held low 5 cycles mid-stream -> out_vec/out_last stable throughout; no beat lost or duplicated.
REQ-032 Reset mid-EMIT: rst_n low during beat 2 of 4 -> outputs zero immediately; after release req_ready=1 and no residual beats.
REQ-033 LFSR mode (macro on): every beat has popcount(out_vec) == out_weight; the rot sequence matches a reference model seeded 8'h01 over 1000 beats.
